noc_output_port: RTL

Transmit side of a router link: collects flits from the router's input ports and drives them into the neighbouring router's input-port buffer. Each packet wins the output through a round-robin arbiter and holds it until its tail flit. Flits leave through a registered link interface (`data_o`/`write_en_o`) under credit-based flow control, so the downstream 5-deep input FIFO never overflows. One instance per router output direction.

---
 rtl/noc_pkg.sv | 19 +
 rtl/noc_rr_arbiter.sv | 32 +++
 rtl/noc_output_port.sv | 139 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit-type encoding and default link credit depth.
package noc_pkg;

  localparam int FLIT_W          = 16;
  localparam int DEFAULT_CREDITS = 5;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  // The type field occupies the two most significant bits of every flit.
  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module noc_rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the closest requester to ptr is the last writer.
  always_comb begin
    gnt = '0;
    sum = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N)) begin
        sum = sum - (PTR_W + 1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_port.sv
// Router output port: round-robin packet arbitration with wormhole lock, credit flow control
// and a registered link interface towards the neighbouring router's input buffer.
module noc_output_port #(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int CREDITS = noc_pkg::DEFAULT_CREDITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN-1:0]              req_i,
  input  logic [NUM_IN-1:0][FLIT_W-1:0]  data_i,
  output logic [NUM_IN-1:0]              shift_o,
  output logic [FLIT_W-1:0]              data_o,
  output logic                           write_en_o,
  input  logic                           credit_i,
  output logic [NUM_IN-1:0]              grant_o,
  output logic                           busy_o,
  output logic                           err_o
);

  import noc_pkg::*;

  localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [FLIT_W-1:0] data_q, data_d;

  logic [NUM_IN-1:0] arb_gnt;
  logic [NUM_IN-1:0] sel;
  logic [NUM_IN-1:0] owner_oh;
  logic [PTR_W-1:0]  sel_idx;
  logic [FLIT_W-1:0] sel_flit;
  logic              send;
  flit_type_e        sel_type;

  noc_rr_arbiter #(
    .N     (NUM_IN),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Pop is suppressed while reset is asserted so no input buffer drains during reset.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    sel               = '0;
    if (rst_n && (cred_q != '0)) begin
      if (state_q == ST_IDLE) begin
        sel = arb_gnt;
      end else if (req_i[owner_q]) begin
        sel = owner_oh;
      end
    end
    send    = |sel;
    sel_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel[i]) begin
        sel_idx = PTR_W'(i);
      end
    end
    sel_flit = data_i[sel_idx];
    sel_type = flit_type(sel_flit);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (send) begin
      if (state_q == ST_IDLE) begin
        ptr_d = (sel_idx == PTR_W'(NUM_IN - 1)) ? '0 : sel_idx + PTR_W'(1);
        if (sel_type == HEAD) begin
          state_d = ST_LOCKED;
          owner_d = sel_idx;
        end
      end else if ((sel_type == TAIL) || (sel_type == SINGLE)) begin
        state_d = ST_IDLE;
      end
    end
  end

  // A credit with nothing in flight downstream means the neighbour popped an empty buffer.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (send && !credit_i) begin
      cred_d = cred_q - CRED_W'(1);
    end else if (!send && credit_i) begin
      if (cred_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        cred_d = cred_q + CRED_W'(1);
      end
    end
    wen_d  = send;
    data_d = send ? sel_flit : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cred_q  <= CRED_MAX;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
    end
  end

  assign shift_o    = sel;
  assign data_o     = data_q;
  assign write_en_o = wen_q;
  assign grant_o    = (state_q == ST_LOCKED) ? owner_oh : '0;
  assign busy_o     = (state_q == ST_LOCKED);
  assign err_o      = err_q;

endmodule
